// File: rtl/shading_pkg.sv
// Shared types, fixed-point constants and the channel quantiser for the shading pixel writer.
// Build option: SHADING_PIXEL_ROUND_EN selects round-to-nearest instead of truncation.
package shading_pkg;

    localparam logic [31:0] FIP_ONE       = 32'h0001_0000;
    localparam logic [31:0] FIP_HALF_LSB8 = 32'h0000_0080;

    typedef logic signed [31:0] rgb_fip_t [0:2];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } pixel_wr_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} pw_state_t;

    // Evaluated in 33 bits so the rounding bias cannot wrap a large positive value negative.
    function automatic logic [7:0] quant_channel(input logic signed [31:0] value);
        logic [32:0] biased;
        logic [7:0]  result;
        biased = {1'b0, value};
`ifdef SHADING_PIXEL_ROUND_EN
        biased = biased + {1'b0, FIP_HALF_LSB8};
`endif
        if (value < 0)
            result = 8'h00;
        else if (biased >= {1'b0, FIP_ONE})
            result = 8'hFF;
        else
            result = biased[15:8];
        return result;
    endfunction

endpackage

// File: rtl/shading_sync_fifo.sv
// Synchronous FIFO with an explicit occupancy count; entry type and power-of-2 depth are parameters.
// Push while full and pop while empty are ignored.
module shading_sync_fifo #(
    parameter type T     = logic [63:0],
    parameter int  DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  T                         din,
    output T                         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    T                mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/shading_pixel_writer.sv
// Quantises shaded RGB pixels to 0x00RRGGBB, buffers them and issues one framebuffer write per pixel.
// Build option: SHADING_PIXEL_ROUND_EN (round-to-nearest quantisation, see shading_pkg).
//
// state | meaning
// IDLE  | waiting for i_start
// RUN   | accepting pixels until the last pixel of the frame
// DRAIN | every pixel accepted, flushing the write buffer
// DONE  | o_frame_done high for this cycle, then IDLE
module shading_pixel_writer
    import shading_pkg::*;
#(
    parameter logic [31:0] FB_BASE    = 32'h0000_0000,
    parameter int          WIDTH      = 320,
    parameter int          HEIGHT     = 240,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_valid,
    input  rgb_fip_t    i_light,
    output logic        o_ready,
    output logic        o_wr_valid,
    input  logic        i_wr_ready,
    output logic [31:0] o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic        o_busy,
    output logic        o_frame_done
);

    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] LAST_IDX = 32'(WIDTH * HEIGHT - 1);

    pw_state_t       state;
    logic [31:0]     pix_idx;
    logic            busy_q;
    logic            frame_done_q;
    pixel_wr_t       push_entry;
    pixel_wr_t       head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            accept;
    logic            pop;

    assign o_ready      = (state == RUN) && !fifo_full;
    assign accept       = i_valid && o_ready;
    assign o_wr_valid   = !fifo_empty;
    assign pop          = o_wr_valid && i_wr_ready;
    // Gated so stale buffer contents never reach the bus after reset.
    assign o_wr_addr    = o_wr_valid ? head.addr : '0;
    assign o_wr_data    = o_wr_valid ? head.data : '0;
    assign o_busy       = busy_q;
    assign o_frame_done = frame_done_q;

    always_comb begin
        push_entry      = '0;
        push_entry.addr = FB_BASE + (pix_idx << 2);
        push_entry.data = {8'h00, quant_channel(i_light[0]),
                           quant_channel(i_light[1]), quant_channel(i_light[2])};
    end

    shading_sync_fifo #(
        .T     (pixel_wr_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (accept),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            pix_idx      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state   <= RUN;
                        pix_idx <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        pix_idx <= pix_idx + 32'd1;
                        if (pix_idx == LAST_IDX)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave as the final pop retires so the pulse lands the cycle after it.
                    if (fifo_empty || (fifo_count == CW'(1) && pop)) begin
                        state        <= DONE;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shading_pixel_writer.sv
// Scoreboard bench for shading_pixel_writer: a 320x240 instance for datapath, backpressure and
// reset cases, and a 4x2 instance for whole-frame sequencing.
module tb_shading_pixel_writer;
    import shading_pkg::*;

    localparam logic [31:0] BASE_A = 32'h1000_0000;
    localparam logic [31:0] BASE_B = 32'h0004_0000;
`ifdef SHADING_PIXEL_ROUND_EN
    localparam logic [7:0] R_ROUND = 8'h81;
`else
    localparam logic [7:0] R_ROUND = 8'h80;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic valid = 1'b0;
    logic wr_ready = 1'b0;
    rgb_fip_t light;

    logic a_ready, a_wr_valid, a_busy, a_done;
    logic [31:0] a_addr, a_data;
    logic b_ready, b_wr_valid, b_busy, b_done;
    logic [31:0] b_addr, b_data;

    int n_tests = 0;
    int n_fail = 0;
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    int idx_a = 0;
    int idx_b = 0;
    int pops_b = 0;
    logic done_due_b = 1'b0;
    logic [31:0] last_addr_b = '0;

    always #5 clk = ~clk;

    shading_pixel_writer #(.FB_BASE(BASE_A)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_valid(valid), .i_light(light),
        .o_ready(a_ready), .o_wr_valid(a_wr_valid), .i_wr_ready(wr_ready),
        .o_wr_addr(a_addr), .o_wr_data(a_data), .o_busy(a_busy), .o_frame_done(a_done)
    );

    shading_pixel_writer #(.FB_BASE(BASE_B), .WIDTH(4), .HEIGHT(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_valid(valid), .i_light(light),
        .o_ready(b_ready), .o_wr_valid(b_wr_valid), .i_wr_ready(wr_ready),
        .o_wr_addr(b_addr), .o_wr_data(b_data), .o_busy(b_busy), .o_frame_done(b_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] tq(input logic signed [31:0] v);
        longint x;
        x = longint'(v);
        if (x < 0) return 8'h00;
`ifdef SHADING_PIXEL_ROUND_EN
        x = x + 128;
`endif
        if (x >= 65536) return 8'hFF;
        return 8'(x / 256);
    endfunction

    function automatic logic [31:0] pixel_model(input rgb_fip_t l);
        return {8'h00, tq(l[0]), tq(l[1]), tq(l[2])};
    endfunction

    function automatic logic signed [31:0] rand_ch();
        logic signed [31:0] v;
        if ($urandom_range(0, 3) == 0) v = $urandom;
        else v = $urandom_range(0, 32'h0001_2000);
        return v;
    endfunction

    // Scoreboard: check the head each cycle, retire on handshake, enqueue on acceptance.
    always @(negedge clk) begin
        if (!rst) begin
            chk("a_wr_valid", 64'(a_wr_valid), 64'(qa.size() != 0));
            chk("a_frame_done", 64'(a_done), 64'(0));
            if (a_wr_valid && qa.size() != 0) begin
                chk("a_wr_addr", 64'(a_addr), 64'(qa[0][63:32]));
                chk("a_wr_data", 64'(a_data), 64'(qa[0][31:0]));
                if (wr_ready) void'(qa.pop_front());
            end
            chk("b_wr_valid", 64'(b_wr_valid), 64'(qb.size() != 0));
            chk("b_frame_done", 64'(b_done), 64'(done_due_b));
            done_due_b = 1'b0;
            if (b_wr_valid && qb.size() != 0) begin
                chk("b_wr_addr", 64'(b_addr), 64'(qb[0][63:32]));
                chk("b_wr_data", 64'(b_data), 64'(qb[0][31:0]));
                if (wr_ready) begin
                    void'(qb.pop_front());
                    pops_b++;
                    last_addr_b = b_addr;
                    if (pops_b == 8) done_due_b = 1'b1;
                end
            end
            if (valid && a_ready) begin
                qa.push_back({BASE_A + 32'(idx_a) * 32'd4, pixel_model(light)});
                idx_a++;
            end
            if (valid && b_ready) begin
                qb.push_back({BASE_B + 32'(idx_b) * 32'd4, pixel_model(light)});
                idx_b++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit to_b, input logic signed [31:0] r, input logic signed [31:0] g,
                        input logic signed [31:0] b);
        bit got;
        got = 1'b0;
        light[0] = r; light[1] = g; light[2] = b;
        valid = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = to_b ? b_ready : a_ready;
            tick();
        end
        valid = 1'b0;
        if (!got) chk("send_timeout", 64'(got), 64'(1));
    endtask

    task automatic wait_drain();
        bit empty_seen;
        empty_seen = 1'b0;
        for (int i = 0; i < 500 && !empty_seen; i++) begin
            @(negedge clk);
            empty_seen = (qa.size() == 0 && qb.size() == 0 && !a_wr_valid && !b_wr_valid);
        end
        chk("drain_done", 64'(empty_seen), 64'(1));
        tick();
    endtask

    task automatic pulse_reset();
        tick();
        rst = 1'b1;
        qa.delete();
        qb.delete();
        done_due_b = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_a_zero(input string tag);
        chk({tag, "_ready"}, 64'(a_ready), 64'(0));
        chk({tag, "_wr_valid"}, 64'(a_wr_valid), 64'(0));
        chk({tag, "_wr_addr"}, 64'(a_addr), 64'(0));
        chk({tag, "_wr_data"}, 64'(a_data), 64'(0));
        chk({tag, "_busy"}, 64'(a_busy), 64'(0));
        chk({tag, "_frame_done"}, 64'(a_done), 64'(0));
    endtask

    initial begin
        bit seen;
        for (int k = 0; k < 3; k++) light[k] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_a_zero("rst_a");
        chk("rst_b_ready", 64'(b_ready), 64'(0));
        chk("rst_b_busy", 64'(b_busy), 64'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 64'(a_ready), 64'(0));

        // Quantisation and rounding on a fresh frame
        tick(); start_a = 1'b1; idx_a = 0;
        tick(); start_a = 1'b0;
        @(negedge clk);
        chk("run_busy", 64'(a_busy), 64'(1));
        chk("run_ready", 64'(a_ready), 64'(1));
        tick();
        wr_ready = 1'b0;
        send(0, 32'h0000_8000, 32'hFFFF_0000, 32'h0002_0000);
        @(negedge clk);
        chk("quant_data", 64'(a_data), 64'(32'h0080_00FF));
        chk("quant_addr", 64'(a_addr), 64'(BASE_A));
        tick(); wr_ready = 1'b1;
        tick(); wr_ready = 1'b0;
        send(0, 32'h0000_80C0, 32'h0, 32'h0);
        @(negedge clk);
        chk("round_data", 64'(a_data), 64'({8'h00, R_ROUND, 16'h0000}));
        tick(); wr_ready = 1'b1;
        send(0, 32'h0000_FFFF, 32'h0001_0000, 32'hFFFF_FFFF);
        send(0, 32'h7FFF_FFFF, 32'h0000_FF80, 32'h8000_0000);
        for (int i = 0; i < 4; i++) begin
            wr_ready = 1'($urandom_range(0, 1));
            send(0, rand_ch(), rand_ch(), rand_ch());
        end
        wr_ready = 1'b1;
        wait_drain();

        // Mid-frame reset discards buffered pixels
        wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(0, rand_ch(), rand_ch(), rand_ch());
        tick();
        rst = 1'b1;
        qa.delete(); qb.delete();
        @(negedge clk);
        check_a_zero("midrst");
        tick();
        wr_ready = 1'b1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_a_zero("post_rst");
        end
        tick(); start_a = 1'b1; idx_a = 0;
        tick(); start_a = 1'b0;

        // Backpressure, full FIFO and simultaneous push/pop
        wr_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(0, rand_ch(), rand_ch(), rand_ch());
        @(negedge clk);
        chk("full_ready", 64'(a_ready), 64'(0));
        tick();
        @(negedge clk);
        chk("full_ready_hold", 64'(a_ready), 64'(0));
        tick();
        light[0] = 32'h0000_4000; light[1] = 32'h0000_C000; light[2] = 32'h0000_0100;
        valid = 1'b1;
        wr_ready = 1'b1;
        @(negedge clk);
        chk("pushpop_ready", 64'(a_ready), 64'(0));
        tick();
        wr_ready = 1'b0;
        @(negedge clk);
        chk("ready_after_pop", 64'(a_ready), 64'(1));
        tick();
        valid = 1'b0;
        @(negedge clk);
        chk("refull_ready", 64'(a_ready), 64'(0));
        tick();
        wr_ready = 1'b1;
        send(0, rand_ch(), rand_ch(), rand_ch());
        wait_drain();
        chk("bp_pixel_count", 64'(idx_a), 64'(10));
        pulse_reset();

        // Whole 4x2 frame; a start pulse mid-frame must be ignored
        idx_b = 0; pops_b = 0;
        tick(); start_b = 1'b1;
        tick(); start_b = 1'b0;
        @(negedge clk);
        chk("frame_busy", 64'(b_busy), 64'(1));
        tick();
        for (int i = 0; i < 8; i++) begin
            wr_ready = (i % 3 != 2);
            start_b = (i == 3);
            send(1, rand_ch(), rand_ch(), rand_ch());
        end
        start_b = 1'b0;
        light[0] = 32'h0000_1000;
        valid = 1'b1;
        @(negedge clk);
        chk("ninth_ready", 64'(b_ready), 64'(0));
        tick();
        valid = 1'b0;
        wr_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = b_done;
        end
        chk("frame_done_seen", 64'(seen), 64'(1));
        @(negedge clk);
        chk("frame_busy_after", 64'(b_busy), 64'(0));
        chk("frame_writes", 64'(pops_b), 64'(8));
        chk("frame_last_addr", 64'(last_addr_b), 64'(BASE_B + 32'd28));
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/shading_pixel_writer.md
Name: shading_pixel_writer

Overview:
- Downstream consumer of the shading stage: accepts per-pixel RGB light values (signed 16.16 fixed point) and quantises each channel to 8 bits.
- Packs each pixel as 0x00RRGGBB and buffers it in a small FIFO.
- Issues framebuffer write requests (address plus data) over a valid/ready interface to the memory writer.
- Tracks pixel position within a frame and signals frame completion after all writes drain.

Parameters:
- FB_BASE, 32'h0000_0000, byte address of pixel 0.
- WIDTH, 320, pixels per row.
- HEIGHT, 240, rows per frame.
- FIFO_DEPTH, 8, write-buffer entries; must be a power of 2, at least 2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  single-cycle pulse that begins a frame; honoured only in IDLE.
- i_valid  in  1  shading result valid.
- i_light  in  signed 32 x [0:2]  RGB channels in 16.16 fixed point.
- o_ready  out  1  block accepts i_light this cycle.
- o_wr_valid  out  1  write request valid.
- i_wr_ready  in  1  memory writer accepts the request.
- o_wr_addr  out  32  byte address of the write.
- o_wr_data  out  32  packed pixel, 0x00RRGGBB.
- o_busy  out  1  high in RUN and DRAIN.
- o_frame_done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset: every output is 0, FIFO is empty, pixel counter is 0, state is IDLE. Reset asserted mid-frame discards all buffered pixels and issues no further writes.
- States and transitions:
  - IDLE: i_start moves to RUN and clears the pixel counter.
  - RUN: moves to DRAIN when the last pixel (index WIDTH*HEIGHT-1) is accepted.
  - DRAIN: moves to DONE when the FIFO is empty and no write is pending.
  - DONE: asserts o_frame_done for one cycle, then returns to IDLE.
- i_start is ignored outside IDLE.
- Input handshake:
  - o_ready = (state==RUN) && !fifo_full.
  - A transfer occurs when i_valid && o_ready.
  - Input ignored while o_ready is low; no bypass write into a full FIFO, even when a pop happens in the same cycle.
- Quantisation, per channel, in this order:
  - value < 0 -> 0.
  - value >= 32'h0001_0000 -> 255.
  - otherwise bits [15:8].
- Address: FB_BASE + 4*index. index = row*WIDTH + col is held as a linear counter that increments per accepted pixel; the address is stored with the data in the FIFO.
- Latency: a pixel accepted in cycle N appears at the FIFO head, with o_wr_valid high, in cycle N+1 at the earliest.
- Write handshake:
  - o_wr_valid = !fifo_empty.
  - o_wr_addr and o_wr_data are held stable while o_wr_valid && !i_wr_ready.
  - Pop occurs on o_wr_valid && i_wr_ready.
  - Push and pop in the same cycle leave the count unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is tracked explicitly so that full and empty are unambiguous.
- Frames are never truncated: exactly WIDTH*HEIGHT writes are issued per frame.

Optional Feature:
- Macro: SHADING_PIXEL_ROUND_EN.
- Defined: each non-negative channel first adds 32'h0000_0080, then saturates to 255, then takes bits [15:8] (round to nearest).
- Undefined: truncation as described in Behaviour.
- Negative clamping applies in both cases.

Decomposition:
- Shared package shading_pkg:
  - fixed-point constants FIP_ONE = 32'h0001_0000 and FIP_HALF_LSB8 = 32'h0000_0080.
  - typedef rgb_fip_t (3 x signed 32).
  - typedef pixel_wr_t (struct: addr 32, data 32).
  - enum pw_state_t {IDLE, RUN, DRAIN, DONE}.
- One sub-module, shading_sync_fifo: parameterised on entry type and depth, synchronous, with push, pop, full, empty and count.
- Quantisation is a package function, not a module.

Test Plan:
- Quantisation: i_light = {32'h0000_8000, 32'hFFFF_0000, 32'h0002_0000} -> o_wr_data 0x00_80_00_FF at o_wr_addr FB_BASE.
- Rounding: i_light[0] = 32'h0000_80C0 -> R = 0x80 without the macro, 0x81 with SHADING_PIXEL_ROUND_EN.
- Backpressure:
  - Hold i_wr_ready = 0 and drive 10 pixels.
  - o_ready drops after 8 accepts.
  - Release i_wr_ready: 10 writes, addresses FB_BASE+0 through +36 in order, data unchanged while stalled.
- Full frame with WIDTH=4, HEIGHT=2:
  - i_start then 8 pixels -> 8 writes, last at FB_BASE+28.
  - o_frame_done pulses one cycle after the final pop.
  - A 9th i_valid is not accepted (o_ready = 0).
- Mid-frame reset:
  - Accept 3 pixels with i_wr_ready = 0, then pulse i_rst.
  - All outputs are 0 and no writes occur.
  - Next i_start restarts at FB_BASE.
- Simultaneous push/pop at FIFO count 8 (full): o_ready stays 0, count remains 8 → 7 after the pop, and o_ready reasserts the following cycle.
